multi_lane_adder_acc: RTL

MULTI_LANE_ADDER_ACC -- requirements
Module: multi_lane_adder_acc

---
 rtl/multi_lane_adder_acc.sv | 106 ++++++++++
 1 files changed

// File: rtl/multi_lane_adder_acc.sv
// Multi-lane unsigned add/sub/accumulate unit with a one-deep valid/ready output register.
// Lanes are fully independent; SAT selects wrap-around or clamping arithmetic.
module multi_lane_adder_acc #(
  parameter int WIDTH = 2,
  parameter int LANES = 4,
  parameter int SAT   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ena,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               mode,
  input  logic [LANES*WIDTH-1:0]   op_a,
  input  logic [LANES*WIDTH-1:0]   op_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   sum,
  output logic [LANES-1:0]         carry
);

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;
  localparam logic [1:0] MODE_CLR = 2'b11;

  // Returns {carry, result}; saturates to all-ones on overflow when SAT is set.
  function automatic logic [WIDTH:0] add_lane(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] full;
    full = {1'b0, a} + {1'b0, b};
    if ((SAT != 0) && full[WIDTH]) begin
      full[WIDTH-1:0] = {WIDTH{1'b1}};
    end
    return full;
  endfunction

  // Returns {borrow, result}; the extra bit of the wide difference is the borrow.
  function automatic logic [WIDTH:0] sub_lane(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] full;
    full = {1'b0, a} - {1'b0, b};
    if ((SAT != 0) && full[WIDTH]) begin
      full[WIDTH-1:0] = '0;
    end
    return full;
  endfunction

  logic                   out_valid_q, out_valid_d;
  logic [LANES*WIDTH-1:0] sum_q, sum_d;
  logic [LANES-1:0]       carry_q, carry_d;
  logic [LANES*WIDTH-1:0] acc_q, acc_d;
  logic                   accept;

  assign in_ready  = reset || !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready && ena;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry     = carry_q;

  always_comb begin
    logic [WIDTH:0] lane_res;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    acc_d       = acc_q;
    lane_res    = '0;
    if (ena) begin
      if (accept) begin
        out_valid_d = 1'b1;
        for (int i = 0; i < LANES; i++) begin
          unique case (mode)
            MODE_ADD: lane_res = add_lane(op_a[i*WIDTH +: WIDTH], op_b[i*WIDTH +: WIDTH]);
            MODE_SUB: lane_res = sub_lane(op_a[i*WIDTH +: WIDTH], op_b[i*WIDTH +: WIDTH]);
            MODE_ACC: lane_res = add_lane(acc_q[i*WIDTH +: WIDTH], op_a[i*WIDTH +: WIDTH]);
            MODE_CLR: lane_res = '0;
            default:  lane_res = '0;
          endcase
          sum_d[i*WIDTH +: WIDTH] = lane_res[WIDTH-1:0];
          carry_d[i]              = lane_res[WIDTH];
          if (mode == MODE_ACC || mode == MODE_CLR) begin
            acc_d[i*WIDTH +: WIDTH] = lane_res[WIDTH-1:0];
          end
        end
      end else if (out_ready) begin
        // Result consumed with nothing new behind it; data is left as-is.
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= '0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      acc_q       <= acc_d;
    end
  end

endmodule
